// File: rtl/bridge_q_pkg.sv
// Shared types for the queued AXI-Lite bridge: FSM states, AXI response codes, request record.
// The optional BRIDGE_WSTRB_EN macro adds a byte-strobe field to the queued request.
package bridge_q_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AWW,
    ST_B
  } axi_q_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Fields are sized for the widest supported bridge; narrower builds use the low bits.
  localparam int REQ_MAX_DATA_W  = 64;
  localparam int REQ_MAX_WADDR_W = 32;

  typedef struct packed {
    logic                         r_wb;
    logic [REQ_MAX_WADDR_W-1:0]   addr;
    logic [REQ_MAX_DATA_W-1:0]    data;
`ifdef BRIDGE_WSTRB_EN
    logic [REQ_MAX_DATA_W/8-1:0]  strb;
`endif
  } bridge_req_t;

endpackage

// File: rtl/bridge_req_fifo.sv
// Synchronous request FIFO with registered count; a simultaneous push and pop keeps the count.
module bridge_req_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_bridge_q.sv
// Queued word-addressed request port to AXI4-Lite master, one outstanding transaction.
// Define BRIDGE_WSTRB_EN to add the C_wstrb input and drive W_STRB from the queued request.
module axi_lite_bridge_q
  import bridge_q_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                WADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                C_in_valid,
  output logic                C_in_ready,
  input  logic                C_r_wb,
  input  logic [WADDR_W-1:0]  C_addr,
  input  logic [DATA_W-1:0]   C_data_w,
`ifdef BRIDGE_WSTRB_EN
  input  logic [DATA_W/8-1:0] C_wstrb,
`endif
  output logic                C_out_valid,
  output logic [DATA_W-1:0]   C_data_r,
  output logic [1:0]          C_resp,
  output logic                AR_VALID,
  output logic [ADDR_W-1:0]   AR_ADDR,
  input  logic                AR_READY,
  input  logic                R_VALID,
  input  logic [DATA_W-1:0]   R_DATA,
  input  logic [1:0]          R_RESP,
  output logic                R_READY,
  output logic                AW_VALID,
  output logic [ADDR_W-1:0]   AW_ADDR,
  input  logic                AW_READY,
  output logic                W_VALID,
  output logic [DATA_W-1:0]   W_DATA,
  output logic [DATA_W/8-1:0] W_STRB,
  input  logic                W_READY,
  input  logic                B_VALID,
  input  logic [1:0]          B_RESP,
  output logic                B_READY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SUM_W  = (ADDR_W > WADDR_W + 2) ? ADDR_W : WADDR_W + 2;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  axi_q_state_e        state_q;
  logic                rdy_en_q;
  logic                ar_valid_q, aw_valid_q, w_valid_q, r_ready_q, b_ready_q, out_valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [1:0]          resp_q;

  bridge_req_t         req_in, req_head;
  logic                push, pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [SUM_W-1:0]    byte_addr;
  logic [ADDR_W-1:0]   head_addr;
  logic                unused_bits;

  always_comb begin
    req_in                    = '0;
    req_in.r_wb               = C_r_wb;
    req_in.addr[WADDR_W-1:0]  = C_addr;
    req_in.data[DATA_W-1:0]   = C_data_w;
`ifdef BRIDGE_WSTRB_EN
    req_in.strb[STRB_W-1:0]   = C_wstrb;
`endif
  end

  // Ready is held low until the first edge after reset release.
  assign C_in_ready = rdy_en_q && !fifo_full;
  assign push       = C_in_valid && C_in_ready;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;

  bridge_req_fifo #(
    .WIDTH ($bits(bridge_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (req_in),
    .pop_i   (pop),
    .rdata_o (req_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign byte_addr   = SUM_W'(BASE_ADDR) + SUM_W'({req_head.addr[WADDR_W-1:0], 2'b00});
  assign head_addr   = byte_addr[ADDR_W-1:0];
  assign unused_bits = ^{req_head, fifo_count};

`ifdef BRIDGE_WSTRB_EN
  logic [STRB_W-1:0] wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   wstrb_q <= '0;
    else if (pop) wstrb_q <= req_head.strb[STRB_W-1:0];
  end

  assign W_STRB = wstrb_q;
`else
  assign W_STRB = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_en_q    <= 1'b0;
      ar_valid_q  <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
    end else begin
      rdy_en_q    <= 1'b1;
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            addr_q  <= head_addr;
            wdata_q <= req_head.data[DATA_W-1:0];
            if (req_head.r_wb) begin
              ar_valid_q <= 1'b1;
              state_q    <= ST_AR;
            end else begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= ST_AWW;
            end
          end
        end
        ST_AR: begin
          if (AR_READY) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= ST_R;
          end
        end
        ST_R: begin
          if (R_VALID) begin
            r_ready_q   <= 1'b0;
            out_valid_q <= 1'b1;
            rdata_q     <= R_DATA;
            resp_q      <= R_RESP;
            state_q     <= ST_IDLE;
          end
        end
        ST_AWW: begin
          // AW and W retire independently; leave once neither is still pending.
          if (aw_valid_q && AW_READY) aw_valid_q <= 1'b0;
          if (w_valid_q && W_READY)   w_valid_q  <= 1'b0;
          if ((!aw_valid_q || AW_READY) && (!w_valid_q || W_READY)) begin
            b_ready_q <= 1'b1;
            state_q   <= ST_B;
          end
        end
        ST_B: begin
          if (B_VALID) begin
            b_ready_q   <= 1'b0;
            out_valid_q <= 1'b1;
            rdata_q     <= '0;
            resp_q      <= B_RESP;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign AR_VALID    = ar_valid_q;
  assign AR_ADDR     = addr_q;
  assign AW_VALID    = aw_valid_q;
  assign AW_ADDR     = addr_q;
  assign W_VALID     = w_valid_q;
  assign W_DATA      = wdata_q;
  assign R_READY     = r_ready_q;
  assign B_READY     = b_ready_q;
  assign C_out_valid = out_valid_q;
  assign C_data_r    = rdata_q;
  assign C_resp      = resp_q;

endmodule

// File: tb/tb_axi_lite_bridge_q.sv
// Scoreboard bench for axi_lite_bridge_q: directed requests, reactive AXI slave, decoupled monitor.
module tb_axi_lite_bridge_q;
  import bridge_q_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        C_in_valid = 1'b0, C_r_wb = 1'b0;
  logic [15:0] C_addr = '0;
  logic [31:0] C_data_w = '0;
`ifdef BRIDGE_WSTRB_EN
  logic [3:0]  C_wstrb = '0;
`endif
  logic        C_in_ready, C_out_valid;
  logic [31:0] C_data_r;
  logic [1:0]  C_resp;
  logic        AR_VALID, R_READY, AW_VALID, W_VALID, B_READY;
  logic [31:0] AR_ADDR, AW_ADDR, W_DATA;
  logic [3:0]  W_STRB;
  logic        AR_READY = 1'b0, AW_READY = 1'b0, W_READY = 1'b0;
  logic        R_VALID = 1'b0, B_VALID = 1'b0;
  logic [31:0] R_DATA = '0;
  logic [1:0]  R_RESP = '0, B_RESP = '0;

  axi_lite_bridge_q dut (
    .clk(clk), .rst_n(rst_n),
    .C_in_valid(C_in_valid), .C_in_ready(C_in_ready), .C_r_wb(C_r_wb),
    .C_addr(C_addr), .C_data_w(C_data_w),
`ifdef BRIDGE_WSTRB_EN
    .C_wstrb(C_wstrb),
`endif
    .C_out_valid(C_out_valid), .C_data_r(C_data_r), .C_resp(C_resp),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_STRB(W_STRB), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [1:0] resp; } cmp_t;
  typedef struct { logic [31:0] data; logic [3:0] strb; } wexp_t;

  cmp_t        exp_q[$];
  cmp_t        r_q[$];
  logic [31:0] exp_ar_q[$];
  logic [31:0] exp_aw_q[$];
  wexp_t       exp_w_q[$];
  logic [1:0]  b_q[$];

  int total = 0;
  int bad   = 0;
  int r_delay = 0;
  int w_delay = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic fail1(input string name);
    total++;
    bad++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit rd, input logic [15:0] wa, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] exp_addr,
                       input logic [31:0] sdata, input logic [1:0] sresp);
    logic [3:0] strb_exp;
    int n;
`ifdef BRIDGE_WSTRB_EN
    strb_exp = st;
    C_wstrb  = st;
`else
    strb_exp = 4'hF;
`endif
    if (rd) begin
      exp_ar_q.push_back(exp_addr);
      r_q.push_back('{sdata, sresp});
      exp_q.push_back('{sdata, sresp});
    end else begin
      exp_aw_q.push_back(exp_addr);
      exp_w_q.push_back('{wd, strb_exp});
      b_q.push_back(sresp);
      exp_q.push_back('{32'h0, sresp});
    end
    C_in_valid = 1'b1;
    C_r_wb     = rd;
    C_addr     = wa;
    C_data_w   = wd;
    n = 0;
    while (!C_in_ready && n < 300) begin
      step(1);
      n++;
    end
    if (!C_in_ready) chk("accept_timeout", 64'(C_in_ready), 64'd1);
    step(1);
    C_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      step(1);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  // Reactive R channel: respond after r_delay cycles of R_READY.
  initial begin
    int r_wait;
    cmp_t rr;
    r_wait = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        R_VALID = 1'b0;
        r_wait  = 0;
      end else if (R_VALID && !R_READY) begin
        R_VALID = 1'b0;
      end else if (R_READY && !R_VALID) begin
        if (r_wait >= r_delay && r_q.size() > 0) begin
          rr = r_q.pop_front();
          R_DATA  = rr.data;
          R_RESP  = rr.resp;
          R_VALID = 1'b1;
          r_wait  = 0;
        end else r_wait++;
      end else if (!R_READY) r_wait = 0;
    end
  end

  // W_READY rises w_delay cycles after W_VALID.
  initial begin
    int w_cnt;
    w_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !W_VALID) begin
        W_READY = 1'b0;
        w_cnt   = 0;
      end else if (!W_READY) begin
        if (w_cnt >= w_delay) W_READY = 1'b1;
        else w_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) B_VALID = 1'b0;
      else if (B_VALID && !B_READY) B_VALID = 1'b0;
      else if (B_READY && !B_VALID && b_q.size() > 0) begin
        B_RESP  = b_q.pop_front();
        B_VALID = 1'b1;
      end
    end
  end

  // Monitor: completions and AXI request side against the expectation queues.
  initial begin
    cmp_t  ce;
    wexp_t we;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (C_out_valid) begin
          if (exp_q.size() == 0) fail1("unexpected_completion");
          else begin
            ce = exp_q.pop_front();
            chk("cmp_data", 64'(C_data_r), 64'(ce.data));
            chk("cmp_resp", 64'(C_resp), 64'(ce.resp));
          end
        end
        if (AR_VALID && AR_READY) begin
          if (exp_ar_q.size() == 0) fail1("unexpected_ar");
          else chk("ar_addr", 64'(AR_ADDR), 64'(exp_ar_q.pop_front()));
        end
        if (AW_VALID && AW_READY) begin
          if (exp_aw_q.size() == 0) fail1("unexpected_aw");
          else chk("aw_addr", 64'(AW_ADDR), 64'(exp_aw_q.pop_front()));
        end
        if (W_VALID) begin
          if (exp_w_q.size() == 0) fail1("unexpected_w");
          else begin
            we = exp_w_q[0];
            chk("w_data", 64'(W_DATA), 64'(we.data));
            chk("w_strb", 64'(W_STRB), 64'(we.strb));
            if (W_READY) void'(exp_w_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(2);
    chk("rst_in_ready", 64'(C_in_ready), 64'd0);
    chk("rst_out_valid", 64'(C_out_valid), 64'd0);
    chk("rst_ar_valid", 64'(AR_VALID), 64'd0);
    chk("rst_aw_w_valid", 64'({AW_VALID, W_VALID}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("in_ready_after_rst", 64'(C_in_ready), 64'd1);

    // Read, addr 3 -> 0x8000_000C, first-transaction latency
    AR_READY = 1'b1;
    AW_READY = 1'b1;
    issue(1'b1, 16'h0003, 32'h0, 4'h0, 32'h8000_000C, 32'hDEAD_BEEF, RESP_OKAY);
    chk("lat_ar_low_k", 64'(AR_VALID), 64'd0);
    step(1);
    chk("lat_ar_high_k2", 64'(AR_VALID), 64'd1);
    chk("lat_ar_addr", 64'(AR_ADDR), 64'h8000_000C);
    drain();

    // Write with W_READY delayed 3 cycles
    w_delay = 3;
    issue(1'b0, 16'h0005, 32'h1234_5678, 4'hF, 32'h8000_0014, 32'h0, RESP_OKAY);
    step(1);
    chk("wr_both_valid", 64'({AW_VALID, W_VALID}), 64'b11);
    step(1);
    chk("wr_aw_drop_first", 64'({AW_VALID, W_VALID}), 64'b01);
    step(2);
    chk("wr_w_held", 64'({W_VALID, B_READY}), 64'b10);
    step(1);
    chk("wr_b_ready", 64'({W_VALID, B_READY}), 64'b01);
    drain();
    w_delay = 0;

    // Five back-to-back reads with AR stalled
    AR_READY = 1'b0;
    issue(1'b1, 16'h000A, 32'h0, 4'h0, 32'h8000_0028, 32'h1000_000A, RESP_OKAY);
    issue(1'b1, 16'h000B, 32'h0, 4'h0, 32'h8000_002C, 32'h1000_000B, RESP_EXOKAY);
    issue(1'b1, 16'h000C, 32'h0, 4'h0, 32'h8000_0030, 32'h1000_000C, RESP_SLVERR);
    issue(1'b1, 16'h000D, 32'h0, 4'h0, 32'h8000_0034, 32'h1000_000D, RESP_DECERR);
    issue(1'b1, 16'h000E, 32'h0, 4'h0, 32'h8000_0038, 32'h1000_000E, RESP_OKAY);
    chk("full_in_ready", 64'(C_in_ready), 64'd0);
    step(3);
    chk("full_in_ready_hold", 64'(C_in_ready), 64'd0);
    chk("stall_ar_addr", 64'({AR_VALID, AR_ADDR}), {31'd0, 1'b1, 32'h8000_0028});
    AR_READY = 1'b1;
    drain();

    // Write with SLVERR, then a queued read
    issue(1'b0, 16'h0040, 32'hA5A5_5A5A, 4'hF, 32'h8000_0100, 32'h0, RESP_SLVERR);
    issue(1'b1, 16'h0041, 32'h0, 4'h0, 32'h8000_0104, 32'h0BAD_F00D, RESP_OKAY);
    drain();

`ifdef BRIDGE_WSTRB_EN
    w_delay = 2;
    issue(1'b0, 16'h0007, 32'h0F0F_0F0F, 4'b0101, 32'h8000_001C, 32'h0, RESP_OKAY);
    drain();
    w_delay = 0;
`endif

    // Reset while a read sits in R with two more queued
    r_delay = 1000;
    issue(1'b1, 16'h0014, 32'h0, 4'h0, 32'h8000_0050, 32'h1111_1111, RESP_OKAY);
    issue(1'b1, 16'h0015, 32'h0, 4'h0, 32'h8000_0054, 32'h2222_2222, RESP_OKAY);
    issue(1'b1, 16'h0016, 32'h0, 4'h0, 32'h8000_0058, 32'h3333_3333, RESP_OKAY);
    step(2);
    chk("inflight_r_ready", 64'(R_READY), 64'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_ar_q.delete();
    r_q.delete();
    chk("arst_ctrl", 64'({AR_VALID, AW_VALID, W_VALID, R_READY, B_READY, C_out_valid, C_in_ready}), 64'd0);
    chk("arst_cdata", 64'(C_data_r), 64'd0);
    chk("arst_resp_addr", 64'({C_resp, AR_ADDR}), 64'd0);
    chk("arst_wdata", 64'({AW_ADDR, W_DATA}), 64'd0);
    r_delay = 0;
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_idle", 64'({AR_VALID, C_out_valid}), 64'd0);
    chk("post_rst_ready", 64'(C_in_ready), 64'd1);
    issue(1'b1, 16'h001E, 32'h0, 4'h0, 32'h8000_0078, 32'hCAFE_F00D, RESP_OKAY);
    drain();

    step(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
